// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO input port: register map, edge
// selection encodings and the debounce counter width helper.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter must hold DEBOUNCE_CYCLES-1; a single-cycle debounce still needs one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: two-flop synchronizer followed by a stability counter that
// accepts a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic deb_o
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next debounced level and counter.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer, debounced level and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input port: debounced levels, edge capture with sticky bits,
// maskable level interrupt, registered read data with latency one.
module pio_in_debounce_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic [31:0]      rd_word_s;
  logic             rd_en_s;
  logic             wr_en_s;
  logic             unused_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .in_i  (in_port[i]),
      .deb_o (deb_s[i])
    );
  end

  assign rd_en_s  = chipselect & ~read_n;
  assign wr_en_s  = chipselect & ~write_n;
  assign unused_s = ^writedata;

  // Edge selection on the debounced levels.
  always_comb begin
    edge_s = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_s = deb_s & ~deb_q;
      EDGE_FALLING: edge_s = ~deb_s & deb_q;
      EDGE_ANY:     edge_s = deb_s ^ deb_q;
      default:      edge_s = deb_s & ~deb_q;
    endcase
  end

  // Register writes; a new edge overrides a simultaneous clear of the same bit.
  always_comb begin
    mask_d = mask_q;
    clr_s  = '0;
    if (wr_en_s && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end else if (wr_en_s && (address == ADDR_EDGE)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    edge_d = (edge_q & ~clr_s) | edge_s;
  end

  // Read mux; the value is held until the next read strobe.
  always_comb begin
    rd_word_s = '0;
    case (address)
      ADDR_DATA: rd_word_s[WIDTH-1:0] = deb_s;
      ADDR_MASK: rd_word_s[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_word_s[WIDTH-1:0] = edge_q;
      default:   rd_word_s = '0;
    endcase
    if (rd_en_s) begin
      readdata_d = rd_word_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Register file, edge history and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q      <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= 32'h0000_0000;
    end else begin
      deb_q      <= deb_s;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule
